// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller. It turns the load/store held in
// EX/MEM into a request/ready transaction on a variable-latency data port,
// stalls the upstream pipeline until that transaction completes, and reports
// misaligned addresses and memory timeouts on a one-cycle bus_err pulse.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] RegB_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Mem_Data,
    output logic        reg_writeO,
    output logic        stall,
    output logic        bus_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          err;
    logic          access;
    logic          aligned;

    assign access  = mem_read | mem_write;
    assign aligned = (ALU_Res[1:0] == 2'b00);

    // Access sequencing: issue the request, wait for ready or timeout, then
    // spend one DONE cycle so EX/MEM advances and the access is never re-issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            Mem_Data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            mem_addr  <= ALU_Res;
                            mem_wdata <= RegB_data;
                            // A load wins when both read and write are asserted.
                            mem_we    <= ~mem_read;
                            mem_req   <= 1'b1;
                            cnt       <= '0;
                            err       <= 1'b0;
                            state     <= WAIT;
                        end else begin
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        if (!mem_we) begin
                            Mem_Data <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline control: stall while an access is pending, bubble MEM/WB while
    // stalled, and suppress the register write of a failed access.
    always_comb begin
        stall      = 1'b0;
        reg_writeO = 1'b0;
        bus_err    = 1'b0;
        case (state)
            IDLE: begin
                stall      = access;
                reg_writeO = reg_write & ~access;
            end
            WAIT: begin
                stall = 1'b1;
            end
            DONE: begin
                reg_writeO = reg_write & ~err;
                bus_err    = err;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule
